stage_sequencer_n: RTL
======================

Name: stage_sequencer_n

Overview:
Parametrised successor to the fixed three-stage instruction scheduler. It sequences an instruction through up to NUM_STAGES generic stages. Each stage can be enabled, repeated, made to issue a TX command, and made to wait for RX reply data. In-order reads are tracked with an outstanding-reply counter of depth MAX_OUTSTANDING, where the previous design allowed only a single read in flight. The block sits between instruction decode and the ALU/TX/RX interfaces and gates ALU enable and TX command issue.

Parameters:
NUM_STAGES, 4, number of generic stages; stage index width STAGE_BITS = clog2(NUM_STAGES)
REPEAT_BITS, 2, width of the per-stage extra-repeat count
MAX_OUTSTANDING, 2, maximum reads issued but not yet answered (at least 1)
CMD_BITS, 2, TX command width; must equal TX_CMD_BITS

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_valid  in  1  instruction present; inputs below stable until inst_done
skip  in  1  condition failed; sampled only in IDLE
stage_mask  in  NUM_STAGES  stages to execute
stage_repeat  in  NUM_STAGES*REPEAT_BITS  extra repeats per stage; 0 means run once
stage_sends  in  NUM_STAGES  stage issues one TX command per repeat
stage_cmd  in  NUM_STAGES*CMD_BITS  TX command per stage
stage_reply  in  NUM_STAGES  stage's command expects an RX reply
stage_waits_rx  in  NUM_STAGES  stage's ALU op consumes the oldest reply
inst_done  out  1  combinational completion pulse
stage_idx  out  STAGE_BITS  current stage
repeat_idx  out  REPEAT_BITS  current repeat
last_repeat  out  1  repeat_idx equals the current stage's repeat count
alu_en  out  1  ALU may run this cycle
op_done  in  1  ALU finished the current op
tx_command_valid  out  1  request to start a command
tx_command  out  CMD_BITS  stage_cmd of the current stage
tx_command_started  in  1  command accepted
tx_data_next  in  1  TX consumes payload this cycle
rx_data_valid  in  1  reply payload present
rx_done  in  1  reply finished
outstanding  out  clog2(MAX_OUTSTANDING+1)  replies pending
protocol_error  out  1  sticky: rx_done seen with outstanding == 0

Behaviour:
- Reset:
  - state IDLE; stage_idx 0; repeat_idx 0; cmd_started 0; outstanding 0; protocol_error 0.
  - All combinational outputs are 0 while in IDLE with inst_valid low.
  - Reset mid-instruction discards progress and the outstanding count.
- IDLE:
  - If inst_valid and (skip or stage_mask == 0): inst_done = 1 in the same cycle; no alu_en, no tx_command_valid; remain in IDLE.
  - Else if inst_valid: next cycle enter ACTIVE with stage_idx = lowest set bit of stage_mask and repeat_idx = 0.
- ACTIVE, with s = stage_idx:
  - tx_command_valid = stage_sends[s] && !cmd_started && (!stage_reply[s] || outstanding < MAX_OUTSTANDING).
  - On tx_command_started, set cmd_started <= 1.
  - alu_en = (!stage_sends[s] || (cmd_started && tx_data_next)) && (!stage_waits_rx[s] || (outstanding != 0 && rx_data_valid)).
- op_done in ACTIVE:
  - cmd_started <= 0.
  - If repeat_idx < stage_repeat[s]: repeat_idx increments; stage_idx is unchanged; the command is re-issued.
  - Else stage_idx <= next set bit of stage_mask above s, and repeat_idx <= 0.
  - If no set bit exists above s: inst_done = 1 in the same cycle and the next state is IDLE.
- outstanding counter:
  - Increments on tx_command_started when stage_reply[s] is set.
  - Decrements on rx_done.
  - Both in the same cycle: unchanged.
  - rx_done at 0: stays 0 and protocol_error is set.
  - Never exceeds MAX_OUTSTANDING, because tx_command_valid is gated.
- inst_done does not wait for outstanding to reach 0; replies may drain into the next instruction.
- skip is ignored in ACTIVE.
- Deasserting inst_valid in ACTIVE is a protocol violation; behaviour is undefined.

Decomposition:
- Shared package / common.vh: TX_HEADER_* command codes, the STAGE_BITS computation, and the state encoding (IDLE, ACTIVE).
- One sub-module, next_stage_sel: a priority encoder returning the lowest set bit of stage_mask strictly above a given index, plus a none flag. A from-bit of -1 is used for the IDLE entry.

Test Plan:
1. mask=0011, sends=01, reply=01, waits_rx=10, repeats 0, MAX=2 ->
   - stage 0: tx_command_valid high until started; outstanding becomes 1; alu_en follows tx_data_next.
   - stage 1: alu_en waits for rx_data_valid; rx_done takes outstanding to 0.
   - inst_done coincides with stage 1 op_done.
2. inst_valid with skip=1 and mask=1111 -> inst_done=1 in the same cycle; tx_command_valid and alu_en stay 0; still IDLE next cycle.
3. mask=0100, repeat[2]=3, no sends ->
   - stage_idx goes straight to 2.
   - four op_done pulses drive repeat_idx 0,1,2,3; last_repeat is high only at 3.
   - inst_done comes on the 4th op_done.
4. MAX=2, mask=0111, all sends with reply, no rx ->
   - outstanding reaches 2; stage 2 tx_command_valid is held 0.
   - one rx_done -> tx_command_valid is asserted the next cycle.
5. tx_command_started and rx_done in the same cycle at outstanding=1 -> stays 1. A later rx_done at outstanding 0 -> protocol_error latches 1 and remains set until reset.
6. reset asserted in stage 2, repeat 1, outstanding 2 -> next cycle stage_idx 0, repeat_idx 0, outstanding 0, alu_en 0, inst_done 0.

Source files
------------

// File: rtl/stage_sequencer_n_pkg.sv
// Shared definitions for the generic stage sequencer: FSM encoding, TX header
// codes and the stage-index width helper.
package stage_sequencer_n_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int TX_CMD_BITS = 2;

    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_NOP   = 2'd0;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ  = 2'd1;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE = 2'd2;
    localparam logic [TX_CMD_BITS-1:0] TX_HEADER_ACK   = 2'd3;

    // A single-stage build still needs a 1-bit index to keep port widths legal.
    function automatic int stage_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stage_sequencer_n_next_stage_sel.sv
// Priority encoder: lowest set bit of mask strictly above from_idx.
// from_valid low means "from -1", i.e. the lowest set bit overall.
module next_stage_sel #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_BITS = 2
) (
    input  logic [NUM_STAGES-1:0] mask,
    input  logic                  from_valid,
    input  logic [STAGE_BITS-1:0] from_idx,
    output logic [STAGE_BITS-1:0] next_idx,
    output logic                  none
);

    logic [NUM_STAGES-1:0] above;
    logic [NUM_STAGES-1:0] cand;

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_above
        assign above[gi] = !from_valid || (from_idx < STAGE_BITS'(gi));
    end

    assign cand = mask & above;
    assign none = ~|cand;

    always_comb begin
        next_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (cand[i]) next_idx = STAGE_BITS'(i);
        end
    end

endmodule

// File: rtl/stage_sequencer_n.sv
// Sequences one instruction through up to NUM_STAGES configurable stages,
// gating ALU enable and TX command issue and tracking in-order RX replies.
module stage_sequencer_n
    import stage_sequencer_n_pkg::*;
#(
    parameter int NUM_STAGES      = 4,
    parameter int REPEAT_BITS     = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CMD_BITS        = TX_CMD_BITS,
    parameter int STAGE_BITS      = stage_bits(NUM_STAGES),
    parameter int OUT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              inst_valid,
    input  logic                              skip,
    input  logic [NUM_STAGES-1:0]             stage_mask,
    input  logic [NUM_STAGES*REPEAT_BITS-1:0] stage_repeat,
    input  logic [NUM_STAGES-1:0]             stage_sends,
    input  logic [NUM_STAGES*CMD_BITS-1:0]    stage_cmd,
    input  logic [NUM_STAGES-1:0]             stage_reply,
    input  logic [NUM_STAGES-1:0]             stage_waits_rx,
    output logic                              inst_done,
    output logic [STAGE_BITS-1:0]             stage_idx,
    output logic [REPEAT_BITS-1:0]            repeat_idx,
    output logic                              last_repeat,
    output logic                              alu_en,
    input  logic                              op_done,
    output logic                              tx_command_valid,
    output logic [CMD_BITS-1:0]               tx_command,
    input  logic                              tx_command_started,
    input  logic                              tx_data_next,
    input  logic                              rx_data_valid,
    input  logic                              rx_done,
    output logic [OUT_BITS-1:0]               outstanding,
    output logic                              protocol_error
);

    localparam logic [OUT_BITS-1:0] MAX_OUT = OUT_BITS'(MAX_OUTSTANDING);

    state_t                  state_q, state_d;
    logic [STAGE_BITS-1:0]   stage_idx_q, stage_idx_d;
    logic [REPEAT_BITS-1:0]  repeat_idx_q, repeat_idx_d;
    logic                    cmd_started_q, cmd_started_d;
    logic [OUT_BITS-1:0]     outstanding_q, outstanding_d;
    logic                    protocol_error_q, protocol_error_d;

    logic [REPEAT_BITS-1:0]  rep_arr [NUM_STAGES];
    logic [CMD_BITS-1:0]     cmd_arr [NUM_STAGES];

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_unpack
        assign rep_arr[gi] = stage_repeat[gi*REPEAT_BITS +: REPEAT_BITS];
        assign cmd_arr[gi] = stage_cmd[gi*CMD_BITS +: CMD_BITS];
    end

    logic                  active;
    logic [STAGE_BITS-1:0] sel_idx;
    logic                  sel_none;
    logic                  rep_done;
    logic                  cnt_inc;

    assign active = (state_q == ACTIVE);

    // In IDLE the search starts below bit 0; in ACTIVE it starts above stage_idx.
    next_stage_sel #(
        .NUM_STAGES(NUM_STAGES),
        .STAGE_BITS(STAGE_BITS)
    ) u_sel (
        .mask      (stage_mask),
        .from_valid(active),
        .from_idx  (stage_idx_q),
        .next_idx  (sel_idx),
        .none      (sel_none)
    );

    assign rep_done = !(repeat_idx_q < rep_arr[stage_idx_q]);
    assign cnt_inc  = active && tx_command_started && stage_reply[stage_idx_q];

    always_comb begin
        state_d          = state_q;
        stage_idx_d      = stage_idx_q;
        repeat_idx_d     = repeat_idx_q;
        cmd_started_d    = cmd_started_q;
        outstanding_d    = outstanding_q;
        protocol_error_d = protocol_error_q;
        inst_done        = 1'b0;
        tx_command_valid = 1'b0;
        alu_en           = 1'b0;

        if (!active) begin
            if (inst_valid && (skip || stage_mask == '0)) begin
                inst_done = 1'b1;
            end else if (inst_valid) begin
                state_d       = ACTIVE;
                stage_idx_d   = sel_idx;
                repeat_idx_d  = '0;
                cmd_started_d = 1'b0;
            end
        end else begin
            tx_command_valid = stage_sends[stage_idx_q] && !cmd_started_q &&
                               (!stage_reply[stage_idx_q] || outstanding_q < MAX_OUT);
            alu_en = (!stage_sends[stage_idx_q] || (cmd_started_q && tx_data_next)) &&
                     (!stage_waits_rx[stage_idx_q] || (outstanding_q != '0 && rx_data_valid));
            if (tx_command_started) cmd_started_d = 1'b1;
            if (op_done) begin
                cmd_started_d = 1'b0;
                if (!rep_done) begin
                    repeat_idx_d = repeat_idx_q + REPEAT_BITS'(1);
                end else if (sel_none) begin
                    inst_done    = 1'b1;
                    state_d      = IDLE;
                    stage_idx_d  = '0;
                    repeat_idx_d = '0;
                end else begin
                    stage_idx_d  = sel_idx;
                    repeat_idx_d = '0;
                end
            end
        end

        // Replies keep draining across instruction boundaries, so this runs in any state.
        if (cnt_inc && !rx_done) begin
            outstanding_d = outstanding_q + OUT_BITS'(1);
        end else if (rx_done && !cnt_inc) begin
            if (outstanding_q == '0) protocol_error_d = 1'b1;
            else                     outstanding_d    = outstanding_q - OUT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            stage_idx_q      <= '0;
            repeat_idx_q     <= '0;
            cmd_started_q    <= 1'b0;
            outstanding_q    <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            stage_idx_q      <= stage_idx_d;
            repeat_idx_q     <= repeat_idx_d;
            cmd_started_q    <= cmd_started_d;
            outstanding_q    <= outstanding_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign stage_idx      = stage_idx_q;
    assign repeat_idx     = repeat_idx_q;
    assign last_repeat    = active && (repeat_idx_q == rep_arr[stage_idx_q]);
    assign tx_command     = active ? cmd_arr[stage_idx_q] : '0;
    assign outstanding    = outstanding_q;
    assign protocol_error = protocol_error_q;

endmodule
